pipe_hazard_sb: RTL

Parametrised hazard and forwarding unit for the ID stage of the pipelined CPU. It generalises the fixed EXE/MEM forwarding and load-use stall to a configurable number of tracked post-ID stages. It keeps a shadow pipeline of in-flight destination registers, each tagged with the stage at which its result becomes forwardable. ID-stage decode drives it; the datapath's forwarding muxes and PC/IR write enables consume its outputs. Interrupt/exception flushes and global freezes are handled internally.

---
 rtl/pipe_hazard_sb_if.sv | 37 +++
 rtl/pipe_hazard_sb.sv | 102 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_sb_if.sv
// ID-stage decode bundle and hazard/forwarding results exchanged with pipe_hazard_sb.
interface pipe_hazard_sb_if #(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int CW    = 32
);
    localparam int FW = $clog2(DEPTH + 1);

    logic             id_valid;
    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic [AW-1:0]    id_rd;
    logic [1:0]       id_kind;
    logic             id_flush;
    logic [DEPTH-1:0] flush_mask;
    logic             freeze;
    logic [FW-1:0]    fwda;
    logic [FW-1:0]    fwdb;
    logic             nostall;
    logic             issue;
    logic [CW-1:0]    stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rd, id_kind,
        output id_flush, flush_mask, freeze,
        input  fwda, fwdb, nostall, issue, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rd, id_kind,
        input  id_flush, flush_mask, freeze,
        output fwda, fwdb, nostall, issue, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_sb.sv
// Hazard/forwarding unit: shadow pipeline of in-flight destinations, each tagged with
// the slot index at which its result becomes forwardable.
module pipe_hazard_sb #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LD_RDY   = 1,
    parameter int LONG_RDY = 2,
    parameter int CW       = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_sb_if.slave  bus
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_r;
    logic [AW-1:0]    rn_r  [DEPTH];
    logic [FW-1:0]    rdy_r [DEPTH];
    logic [CW-1:0]    stall_cnt_r;

    logic [DEPTH-1:0] match_a_s;
    logic [DEPTH-1:0] match_b_s;
    logic [FW-1:0]    fwda_s;
    logic [FW-1:0]    fwdb_s;
    logic             haz_a_s;
    logic             haz_b_s;
    logic [FW-1:0]    kind_rdy_s;
    logic             nostall_s;
    logic             issue_s;
    logic             load_s;

    // Per-slot source matches; r0 and unused sources never match.
    always_comb begin
        match_a_s = '0;
        match_b_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_a_s[k] = v_r[k] & (rn_r[k] == bus.id_rs) & (bus.id_rs != '0) & bus.id_use_rs;
            match_b_s[k] = v_r[k] & (rn_r[k] == bus.id_rt) & (bus.id_rt != '0) & bus.id_use_rt;
        end
    end

    // Youngest producer wins: scanning oldest-first lets the lowest slot overwrite.
    always_comb begin
        fwda_s  = '0;
        fwdb_s  = '0;
        haz_a_s = 1'b0;
        haz_b_s = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            fwda_s  = match_a_s[k] ? FW'(k + 1) : fwda_s;
            haz_a_s = match_a_s[k] ? (FW'(k) < rdy_r[k]) : haz_a_s;
            fwdb_s  = match_b_s[k] ? FW'(k + 1) : fwdb_s;
            haz_b_s = match_b_s[k] ? (FW'(k) < rdy_r[k]) : haz_b_s;
        end
    end

    // Ready slot index for the instruction in ID.
    always_comb begin
        case (bus.id_kind)
            2'b01:   kind_rdy_s = FW'(LD_RDY);
            2'b10:   kind_rdy_s = FW'(LONG_RDY);
            default: kind_rdy_s = '0;
        endcase
    end

    assign nostall_s = ~(bus.id_valid & (haz_a_s | haz_b_s));
    assign issue_s   = bus.id_valid & nostall_s & ~bus.id_flush & ~bus.freeze;
    assign load_s    = issue_s & bus.id_wreg & (bus.id_rd != '0);

    // Shadow pipeline advance and stall counter; freeze only applies flushes in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r         <= '0;
            stall_cnt_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rn_r[k]  <= '0;
                rdy_r[k] <= '0;
            end
        end else if (bus.freeze) begin
            v_r <= v_r & ~bus.flush_mask;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                v_r[k]   <= v_r[k-1] & ~bus.flush_mask[k-1];
                rn_r[k]  <= rn_r[k-1];
                rdy_r[k] <= rdy_r[k-1];
            end
            v_r[0]   <= load_s;
            rn_r[0]  <= bus.id_rd;
            rdy_r[0] <= kind_rdy_s;
            if (bus.id_valid & ~nostall_s & (stall_cnt_r != '1)) begin
                stall_cnt_r <= stall_cnt_r + CW'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign bus.fwda      = fwda_s;
    assign bus.fwdb      = fwdb_s;
    assign bus.nostall   = nostall_s;
    assign bus.issue     = issue_s;
    assign bus.stall_cnt = stall_cnt_r;
endmodule
